ncl_count_sequencer: RTL and testbench
======================================

# ncl_count_sequencer

Clocked controller for the NCL dual-rail ripple counter built from `WIDTH` chained digit-counter rings. It owns the NCL `init` line and injects increment wavefronts (DATA then NULL) on the least-significant digit's `carryin`. It closes the `sumCOMP`/`carryoutCOMP` handshakes for every digit and presents the settled count as a synchronous binary value. It is the bridge between the asynchronous counter chain and clocked host logic.

## Interface
- `WIDTH`, 32, number of digit rings (binary count width)
- `INIT_CYCLES`, 4, clocks `ncl_init` stays high after reset or clear
- `WD_CYCLES`, 1024, watchdog limit per handshake phase (used only with the macro)

- `clk`  in  1  sole clock
- `init_n`  in  1  reset, synchronous, active-low
- `cmd_valid`  in  1  host requests a count burst
- `cmd_ready`  out  1  high only in IDLE
- `cmd_incs`  in  16  increments to inject; 0 means a no-op burst
- `cmd_clear`  in  1  sampled with `cmd_valid`; reinitialise the chain instead of counting
- `ncl_init`  out  1  active-high NCL init to all digit rings
- `carryin`  out  2  dual-rail carry into digit 0; `[1]`=true, `[0]`=false
- `carryin_comp`  in  1  async completion from digit 0
- `sum_rails`  in  2*WIDTH  async dual-rail sums; digit i on `[2i+1:2i]`
- `sum_comp`  out  1  completion broadcast to every digit's `sumCOMP`
- `msb_carry`  in  2  async dual-rail carryout of the top digit
- `msb_carry_comp`  out  1  completion back to the top digit
- `count_value`  out  WIDTH  last captured count
- `value_valid`  out  1  one-cycle pulse on each capture
- `busy`  out  1  high whenever not in IDLE
- `overflow`  out  1  sticky; set when `msb_carry` shows true DATA
- `wd_err`  out  1  sticky watchdog flag (tied 0 without the macro)

## Operation
- All async inputs pass through 2-flop synchronisers before use: `carryin_comp`, every `sum_rails` bit and both `msb_carry` bits.
- COMP convention: low requests DATA; high acknowledges DATA and requests NULL.
- States:
  - INIT: `ncl_init`=1 and `carryin`=00 for `INIT_CYCLES`. Then go to IDLE, clear `count_value` to 0 and clear `overflow`.
  - IDLE: `cmd_ready`=1.
    - On `cmd_valid` with `cmd_clear`: go to INIT.
    - On `cmd_valid` with `cmd_incs`=0: stay in IDLE.
    - Otherwise: load `remaining`=`cmd_incs` and go to DATA.
  - DATA: `carryin`=10. Wait for synced `carryin_comp`=1, then go to NULL.
  - NULL: `carryin`=00. Wait for synced `carryin_comp`=0, then decrement `remaining`. At 0 go to DRAIN, otherwise go to DATA.
  - DRAIN: wait until the sum handshake is idle with `sum_comp`=0 and the synced rails are all NULL. Then go to IDLE.
- Sum handshake (runs independently of the main FSM):
  - All-DATA means every digit pair is exactly one-hot on two consecutive synced samples. On all-DATA with `sum_comp`=0:
    - set `sum_comp`=1;
    - capture `count_value[i]`=`sum_rails[2i+1]`;
    - pulse `value_valid`.
  - All-NULL means every pair is 00 on two consecutive samples. On all-NULL, clear `sum_comp`.
  - A pair reading 11 is illegal. Treat it as not-complete; never capture it.
- MSB carry handshake:
  - When synced `msb_carry` is one-hot, set `msb_carry_comp`=1. If `msb_carry[1]`=1, also set `overflow`.
  - When synced `msb_carry` is 00, clear `msb_carry_comp`.
- Count wraps modulo 2^WIDTH. `overflow` stays set until INIT.
- A new command is accepted only in IDLE, so at most one burst is in flight.

## Timing
- Reset values: `ncl_init`=1, `carryin`=00, `sum_comp`=0, `msb_carry_comp`=0, `cmd_ready`=0, `busy`=1, `count_value`=0, `value_valid`=0, `overflow`=0, `wd_err`=0. FSM resets to INIT.
- Deassertion of `init_n` at edge T: `ncl_init` falls at T+`INIT_CYCLES`, and `cmd_ready` rises in the same cycle.
- Command accepted at edge T: `carryin`=10 from T+1.
- Handshake latency: a `carryin_comp` change is acted on no earlier than 2 clocks later (synchroniser), plus 1 clock for the FSM transition.
- Capture latency: `value_valid` is asserted no earlier than 3 clocks after the last sum rail settles (2 sync + 1 stability sample).
- Reset asserted mid-burst: abort on the next edge and return to INIT. `carryin` goes to 00 and `ncl_init` to 1 in that same cycle.
- `cmd_clear` with `cmd_valid` in IDLE: INIT is entered on the next edge.

## Configuration
- `NCL_SEQ_WATCHDOG_EN`
  - Defined: a counter runs in each of the DATA, NULL and DRAIN states. If it reaches `WD_CYCLES` without a transition, `wd_err` is set (sticky) and the FSM goes to INIT.
  - Undefined: no counter exists, `wd_err` is tied 0, and a stalled handshake waits forever.

## Test plan
- Reset, then `cmd_incs`=5 → five DATA/NULL pairs on `carryin`; final `count_value`=5; `value_valid` pulses 5 times; `overflow`=0.
- WIDTH=4 model, preload 14, `cmd_incs`=3 → `count_value`=1; `overflow`=1; `msb_carry_comp` toggles exactly once.
- `cmd_incs`=0 → no `carryin` activity; `busy` never rises; `count_value` unchanged.
- One digit model holds a 11 pair → no capture and `sum_comp` stays 0. With `NCL_SEQ_WATCHDOG_EN`, `wd_err`=1 after `WD_CYCLES` and the FSM re-enters INIT.
- Drop `init_n` during the 3rd increment of a 10-increment burst → next edge: `carryin`=00, `ncl_init`=1, `count_value`=0.
- `cmd_clear`=1 after a count of 7 → `ncl_init` high for 4 clocks; `count_value`=0; `overflow` cleared.

Source files
------------

// File: rtl/ncl_count_sequencer.sv
// ncl_count_sequencer
//
// Clocked controller for an NCL dual-rail ripple counter made of WIDTH chained
// digit rings. It drives the NCL init line and injects increment wavefronts
// (DATA then NULL) on digit 0's carry input. It closes the sum and top-carry
// completion handshakes, and presents the settled count as a synchronous
// binary value.
//
// Parameters
//   WIDTH        number of digit rings (binary count width)
//   INIT_CYCLES  clocks ncl_init stays high after reset or a clear command
//   WD_CYCLES    per-phase watchdog limit (only with NCL_SEQ_WATCHDOG_EN)
//
// Ports
//   clk             sole clock
//   init_n          synchronous active-low reset
//   cmd_valid       host requests a count burst
//   cmd_ready       high only in IDLE
//   cmd_incs[15:0]  increments to inject (0 = no-op)
//   cmd_clear       with cmd_valid: reinitialise the chain instead of counting
//   ncl_init        active-high NCL init to every digit ring
//   carryin[1:0]    dual-rail carry into digit 0 ([1]=true, [0]=false)
//   carryin_comp    async completion from digit 0
//   sum_rails       async dual-rail sums, digit i on [2i+1:2i]
//   sum_comp        completion broadcast to every digit's sumCOMP
//   msb_carry[1:0]  async dual-rail carry out of the top digit
//   msb_carry_comp  completion back to the top digit
//   count_value     last captured count
//   value_valid     one-cycle pulse on each capture
//   busy            high whenever not in IDLE
//   overflow        sticky, set by a true carry out of the top digit
//   wd_err          sticky watchdog flag
//
// Build option
//   NCL_SEQ_WATCHDOG_EN  when defined, a per-phase watchdog in DATA, NULL and
//                        DRAIN sets wd_err and forces INIT; when undefined
//                        wd_err is tied low and stalls wait indefinitely.

module ncl_count_sequencer #(
    parameter int WIDTH       = 32,
    parameter int INIT_CYCLES = 4,
    parameter int WD_CYCLES   = 1024
) (
    input  logic               clk,
    input  logic               init_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [15:0]        cmd_incs,
    input  logic               cmd_clear,
    output logic               ncl_init,
    output logic [1:0]         carryin,
    input  logic               carryin_comp,
    input  logic [2*WIDTH-1:0] sum_rails,
    output logic               sum_comp,
    input  logic [1:0]         msb_carry,
    output logic               msb_carry_comp,
    output logic [WIDTH-1:0]   count_value,
    output logic               value_valid,
    output logic               busy,
    output logic               overflow,
    output logic               wd_err
);

    localparam int INIT_W = (INIT_CYCLES < 1) ? 1 : $clog2(INIT_CYCLES + 1);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES);

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_DATA  = 3'd2,
        ST_NULL  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    state_t              state_r;
    logic [INIT_W-1:0]   init_cnt_r;
    logic [15:0]         remaining_r;

    logic                comp_meta_r;
    logic                comp_sync_r;
    logic [2*WIDTH-1:0]  sum_meta_r;
    logic [2*WIDTH-1:0]  sum_sync_r;
    logic [2*WIDTH-1:0]  sum_prev_r;
    logic [1:0]          msb_meta_r;
    logic [1:0]          msb_sync_r;

    logic                all_data_s;
    logic                all_null_s;
    logic                capture_s;
    logic                init_exit_s;
    logic                msb_onehot_s;
    logic                wait_s;
    logic                adv_s;

    // Every pair is exactly one-hot; an illegal 11 pair fails this test.
    function automatic logic rails_all_data(input logic [2*WIDTH-1:0] r);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            ok = ok & (r[2*i+1] ^ r[2*i]);
        end
        return ok;
    endfunction

    // Binary value carried by the true rails.
    function automatic logic [WIDTH-1:0] rails_true(input logic [2*WIDTH-1:0] r);
        logic [WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < WIDTH; i++) begin
            v[i] = r[2*i+1];
        end
        return v;
    endfunction

`ifdef NCL_SEQ_WATCHDOG_EN
    localparam int WD_W = (WD_CYCLES < 2) ? 1 : $clog2(WD_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_CYCLES - 1);
    logic [WD_W-1:0] wd_cnt_r;
    logic            wd_err_r;
    assign wd_err = wd_err_r;
`else
    assign wd_err = 1'b0;
`endif

    // A full wavefront must be seen identically on two consecutive synced samples.
    assign all_data_s   = rails_all_data(sum_sync_r) && rails_all_data(sum_prev_r) &&
                          (sum_sync_r == sum_prev_r);
    assign all_null_s   = (sum_sync_r == '0) && (sum_prev_r == '0);
    assign capture_s    = all_data_s && !sum_comp;
    assign init_exit_s  = (state_r == ST_INIT) && (init_cnt_r == INIT_LAST);
    assign msb_onehot_s = msb_sync_r[1] ^ msb_sync_r[0];

    // Phase-advance condition for each waiting state (also feeds the watchdog).
    always_comb begin
        wait_s = 1'b0;
        adv_s  = 1'b0;
        case (state_r)
            ST_DATA: begin
                wait_s = 1'b1;
                adv_s  = comp_sync_r;
            end
            ST_NULL: begin
                wait_s = 1'b1;
                adv_s  = !comp_sync_r;
            end
            ST_DRAIN: begin
                wait_s = 1'b1;
                adv_s  = !sum_comp && all_null_s;
            end
            default: begin
                wait_s = 1'b0;
                adv_s  = 1'b0;
            end
        endcase
    end

    // Two-flop synchronisers for every asynchronous input, plus one extra
    // sum sample used for the stability check.
    always_ff @(posedge clk) begin
        if (!init_n) begin
            comp_meta_r <= 1'b0;
            comp_sync_r <= 1'b0;
            sum_meta_r  <= '0;
            sum_sync_r  <= '0;
            sum_prev_r  <= '0;
            msb_meta_r  <= 2'b00;
            msb_sync_r  <= 2'b00;
        end else begin
            comp_meta_r <= carryin_comp;
            comp_sync_r <= comp_meta_r;
            sum_meta_r  <= sum_rails;
            sum_sync_r  <= sum_meta_r;
            sum_prev_r  <= sum_sync_r;
            msb_meta_r  <= msb_carry;
            msb_sync_r  <= msb_meta_r;
        end
    end

    // Sum handshake and count capture; leaving INIT zeroes the count.
    always_ff @(posedge clk) begin
        if (!init_n) begin
            sum_comp    <= 1'b0;
            count_value <= '0;
            value_valid <= 1'b0;
        end else begin
            if (capture_s) begin
                sum_comp <= 1'b1;
            end else if (all_null_s) begin
                sum_comp <= 1'b0;
            end else begin
                sum_comp <= sum_comp;
            end

            if (init_exit_s) begin
                count_value <= '0;
            end else if (capture_s) begin
                count_value <= rails_true(sum_sync_r);
            end else begin
                count_value <= count_value;
            end

            value_valid <= capture_s && !init_exit_s;
        end
    end

    // Top-digit carry handshake and sticky overflow.
    always_ff @(posedge clk) begin
        if (!init_n) begin
            msb_carry_comp <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            if (msb_onehot_s) begin
                msb_carry_comp <= 1'b1;
            end else if (msb_sync_r == 2'b00) begin
                msb_carry_comp <= 1'b0;
            end else begin
                msb_carry_comp <= msb_carry_comp;
            end

            if (init_exit_s) begin
                overflow <= 1'b0;
            end else if (msb_onehot_s && msb_sync_r[1]) begin
                overflow <= 1'b1;
            end else begin
                overflow <= overflow;
            end
        end
    end

    // Main sequencer: init hold, command intake, DATA/NULL injection, drain.
    always_ff @(posedge clk) begin
        if (!init_n) begin
            state_r     <= ST_INIT;
            init_cnt_r  <= '0;
            remaining_r <= 16'd0;
            ncl_init    <= 1'b1;
            carryin     <= 2'b00;
            cmd_ready   <= 1'b0;
            busy        <= 1'b1;
`ifdef NCL_SEQ_WATCHDOG_EN
            wd_cnt_r    <= '0;
            wd_err_r    <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_INIT: begin
                    carryin <= 2'b00;
                    if (init_exit_s) begin
                        state_r   <= ST_IDLE;
                        ncl_init  <= 1'b0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        init_cnt_r <= init_cnt_r + INIT_W'(1);
                        ncl_init   <= 1'b1;
                        cmd_ready  <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (cmd_valid && cmd_clear) begin
                        // Counting starts at 1 so ncl_init is high for exactly INIT_CYCLES.
                        state_r    <= ST_INIT;
                        init_cnt_r <= INIT_W'(1);
                        ncl_init   <= 1'b1;
                        carryin    <= 2'b00;
                        cmd_ready  <= 1'b0;
                        busy       <= 1'b1;
                    end else if (cmd_valid && (cmd_incs != 16'd0)) begin
                        state_r     <= ST_DATA;
                        remaining_r <= cmd_incs;
                        carryin     <= 2'b10;
                        cmd_ready   <= 1'b0;
                        busy        <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (adv_s) begin
                        state_r <= ST_NULL;
                        carryin <= 2'b00;
                    end else begin
                        carryin <= 2'b10;
                    end
                end
                ST_NULL: begin
                    if (adv_s) begin
                        remaining_r <= remaining_r - 16'd1;
                        if (remaining_r == 16'd1) begin
                            state_r <= ST_DRAIN;
                            carryin <= 2'b00;
                        end else begin
                            state_r <= ST_DATA;
                            carryin <= 2'b10;
                        end
                    end else begin
                        carryin <= 2'b00;
                    end
                end
                ST_DRAIN: begin
                    if (adv_s) begin
                        state_r   <= ST_IDLE;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                default: begin
                    state_r    <= ST_INIT;
                    init_cnt_r <= INIT_W'(1);
                    ncl_init   <= 1'b1;
                    carryin    <= 2'b00;
                    cmd_ready  <= 1'b0;
                    busy       <= 1'b1;
                end
            endcase

`ifdef NCL_SEQ_WATCHDOG_EN
            // A phase that fails to advance for WD_CYCLES clocks forces INIT.
            if (wait_s && !adv_s) begin
                if (wd_cnt_r == WD_LAST) begin
                    wd_cnt_r   <= '0;
                    wd_err_r   <= 1'b1;
                    state_r    <= ST_INIT;
                    init_cnt_r <= INIT_W'(1);
                    ncl_init   <= 1'b1;
                    carryin    <= 2'b00;
                    cmd_ready  <= 1'b0;
                    busy       <= 1'b1;
                end else begin
                    wd_cnt_r <= wd_cnt_r + WD_W'(1);
                end
            end else begin
                wd_cnt_r <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_ncl_count_sequencer.sv
module tb_ncl_count_sequencer;

    localparam int TW  = 4;
    localparam int TWD = 64;

    logic              clk = 1'b0;
    logic              init_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic [15:0]       cmd_incs = 16'd0;
    logic              cmd_clear = 1'b0;
    logic              cmd_ready;
    logic              ncl_init;
    logic [1:0]        carryin;
    logic              carryin_comp = 1'b0;
    logic [2*TW-1:0]   sum_rails = '0;
    logic              sum_comp;
    logic [1:0]        msb_carry = 2'b00;
    logic              msb_carry_comp;
    logic [TW-1:0]     count_value;
    logic              value_valid;
    logic              busy;
    logic              overflow;
    logic              wd_err;

    // Counter-chain model state
    logic [TW-1:0]     preload_val = '0;
    logic              inject_bad = 1'b0;
    logic [TW-1:0]     m_cnt = '0;
    logic [1:0]        m_st = 2'd0;

    int                errors = 0;
    int                checks = 0;
    logic [TW-1:0]     exp_q[$];
    int                rd_idx = 0;

    ncl_count_sequencer #(
        .WIDTH(TW),
        .INIT_CYCLES(4),
        .WD_CYCLES(TWD)
    ) dut (
        .clk(clk),
        .init_n(init_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_incs(cmd_incs),
        .cmd_clear(cmd_clear),
        .ncl_init(ncl_init),
        .carryin(carryin),
        .carryin_comp(carryin_comp),
        .sum_rails(sum_rails),
        .sum_comp(sum_comp),
        .msb_carry(msb_carry),
        .msb_carry_comp(msb_carry_comp),
        .count_value(count_value),
        .value_valid(value_valid),
        .busy(busy),
        .overflow(overflow),
        .wd_err(wd_err)
    );

    always #5 clk = ~clk;

    function automatic logic [2*TW-1:0] encode(input logic [TW-1:0] v, input logic bad);
        logic [2*TW-1:0] r;
        r = '0;
        for (int i = 0; i < TW; i++) begin
            r[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
        end
        if (bad) begin
            r[1:0] = 2'b11;
        end
        return r;
    endfunction

    // Behavioural digit chain: one increment per DATA wavefront on carryin,
    // holding each phase until the sequencer has acknowledged the sums.
    always @(negedge clk) begin
        if (ncl_init) begin
            m_cnt        <= preload_val;
            m_st         <= 2'd0;
            sum_rails    <= '0;
            msb_carry    <= 2'b00;
            carryin_comp <= 1'b0;
        end else begin
            case (m_st)
                2'd0: if (carryin == 2'b10) begin
                    m_cnt     <= m_cnt + TW'(1);
                    sum_rails <= encode(m_cnt + TW'(1), inject_bad);
                    msb_carry <= (m_cnt == {TW{1'b1}}) ? 2'b10 : 2'b00;
                    m_st      <= 2'd1;
                end
                2'd1: if (sum_comp && ((msb_carry == 2'b00) || msb_carry_comp)) begin
                    carryin_comp <= 1'b1;
                    m_st         <= 2'd2;
                end
                2'd2: if (carryin == 2'b00) begin
                    sum_rails <= '0;
                    msb_carry <= 2'b00;
                    m_st      <= 2'd3;
                end
                default: if (!sum_comp && !msb_carry_comp) begin
                    carryin_comp <= 1'b0;
                    m_st         <= 2'd0;
                end
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic issue(input logic [15:0] incs, input logic clr, input bit expect_data);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_incs  = incs;
        cmd_clear = clr;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_clear = 1'b0;
        if (expect_data) chk("accept_carryin", 32'(carryin), 32'd2);
    endtask

    task automatic wait_idle(input string name, output int ci, output int vv, output int mr);
        logic [1:0] pc;
        logic pm;
        bit done;
        pc = 2'b00; pm = 1'b0; done = 1'b0;
        ci = 0; vv = 0; mr = 0;
        for (int k = 0; k < 3000 && !done; k++) begin
            @(negedge clk);
            if (carryin == 2'b10 && pc != 2'b10) ci++;
            pc = carryin;
            if (msb_carry_comp && !pm) mr++;
            pm = msb_carry_comp;
            if (value_valid) vv++;
            if (cmd_ready && !busy) done = 1'b1;
        end
        chk({name, "_reach_idle"}, 32'(done), 32'd1);
    endtask

    task automatic count_init_high(input string name);
        int n;
        bit done;
        n = 0; done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (ncl_init) n++;
            else done = 1'b1;
        end
        chk({name, "_init_len"}, 32'(n), 32'd4);
        chk({name, "_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: time %0t exceeded limit 500000", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int ci, vv, mr, bz, cz, rz, sc;
        bit found;
        logic [1:0] pc;

        // Scoreboard monitor: every capture pops the next expected count.
        fork
            forever begin
                @(negedge clk);
                if (value_valid) begin
                    if (rd_idx < exp_q.size()) begin
                        chk("capture", 32'(count_value), 32'(exp_q[rd_idx]));
                        rd_idx++;
                    end else begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_capture: got %0d required no capture", count_value);
                    end
                end
            end
        join_none

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_ncl_init", 32'(ncl_init), 32'd1);
        chk("rst_carryin", 32'(carryin), 32'd0);
        chk("rst_sum_comp", 32'(sum_comp), 32'd0);
        chk("rst_msb_comp", 32'(msb_carry_comp), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_count", 32'(count_value), 32'd0);
        chk("rst_vv", 32'(value_valid), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_wd_err", 32'(wd_err), 32'd0);
        init_n = 1'b1;
        count_init_high("rst");

        // Burst of 5 from zero
        for (int v = 1; v <= 5; v++) exp_q.push_back(TW'(v));
        issue(16'd5, 1'b0, 1'b1);
        wait_idle("b5", ci, vv, mr);
        chk("b5_pairs", 32'(ci), 32'd5);
        chk("b5_vv", 32'(vv), 32'd5);
        chk("b5_count", 32'(count_value), 32'd5);
        chk("b5_overflow", 32'(overflow), 32'd0);

        // No-op burst
        issue(16'd0, 1'b0, 1'b0);
        bz = 0; cz = 0; rz = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy) bz++;
            if (carryin != 2'b00) cz++;
            if (!cmd_ready) rz++;
        end
        chk("noop_busy", 32'(bz), 32'd0);
        chk("noop_carryin", 32'(cz), 32'd0);
        chk("noop_ready", 32'(rz), 32'd0);
        chk("noop_count", 32'(count_value), 32'd5);

        // Two more to reach 7, then clear (chain reinitialises to 14)
        exp_q.push_back(TW'(6));
        exp_q.push_back(TW'(7));
        issue(16'd2, 1'b0, 1'b1);
        wait_idle("b2", ci, vv, mr);
        chk("b2_count", 32'(count_value), 32'd7);
        preload_val = TW'(14);
        issue(16'd0, 1'b1, 1'b0);
        count_init_high("clr1");
        preload_val = '0;
        chk("clr1_count", 32'(count_value), 32'd0);
        chk("clr1_overflow", 32'(overflow), 32'd0);

        // 14 + 3 wraps to 1 with overflow
        exp_q.push_back(TW'(15));
        exp_q.push_back(TW'(0));
        exp_q.push_back(TW'(1));
        issue(16'd3, 1'b0, 1'b1);
        wait_idle("wrap", ci, vv, mr);
        chk("wrap_pairs", 32'(ci), 32'd3);
        chk("wrap_count", 32'(count_value), 32'd1);
        chk("wrap_overflow", 32'(overflow), 32'd1);
        chk("wrap_msb_toggles", 32'(mr), 32'd1);

        // Clear drops overflow
        issue(16'd0, 1'b1, 1'b0);
        count_init_high("clr2");
        chk("clr2_count", 32'(count_value), 32'd0);
        chk("clr2_overflow", 32'(overflow), 32'd0);

        // Reset during the 3rd increment of a 10-increment burst
        exp_q.push_back(TW'(1));
        exp_q.push_back(TW'(2));
        issue(16'd10, 1'b0, 1'b1);
        pc = 2'b00; ci = 0; found = 1'b0;
        for (int k = 0; k < 2000 && !found; k++) begin
            if (k > 0) @(negedge clk);
            if (carryin == 2'b10 && pc != 2'b10) ci++;
            pc = carryin;
            if (ci == 3) found = 1'b1;
        end
        chk("abort_third_inc", 32'(found), 32'd1);
        init_n = 1'b0;
        @(negedge clk);
        chk("abort_carryin", 32'(carryin), 32'd0);
        chk("abort_ncl_init", 32'(ncl_init), 32'd1);
        chk("abort_count", 32'(count_value), 32'd0);
        chk("abort_busy", 32'(busy), 32'd1);
        init_n = 1'b1;
        count_init_high("abort");

        // Illegal 11 pair on digit 0: never captured
        inject_bad = 1'b1;
        issue(16'd1, 1'b0, 1'b1);
        sc = 0; vv = 0;
        repeat (40) begin
            @(negedge clk);
            if (sum_comp) sc++;
            if (value_valid) vv++;
        end
        chk("bad_sum_comp", 32'(sc), 32'd0);
        chk("bad_vv", 32'(vv), 32'd0);
        chk("bad_busy", 32'(busy), 32'd1);
`ifdef NCL_SEQ_WATCHDOG_EN
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (wd_err) found = 1'b1;
        end
        chk("wd_fired", 32'(found), 32'd1);
        chk("wd_ncl_init", 32'(ncl_init), 32'd1);
`else
        chk("stall_wd_err", 32'(wd_err), 32'd0);
        chk("stall_carryin", 32'(carryin), 32'd2);
`endif
        inject_bad = 1'b0;
        init_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst2_wd_err", 32'(wd_err), 32'd0);
        chk("rst2_ncl_init", 32'(ncl_init), 32'd1);
        init_n = 1'b1;
        count_init_high("rst2");

        chk("scoreboard_drained", 32'(rd_idx), 32'(exp_q.size()));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
